// File: rtl/sram_scan_pkg.sv
// Shared definitions for the SRAM scan checker: FSM states, default geometry
// and the legal read-latency range.
package sram_scan_pkg;

    localparam int DEPTH_DEF    = 32;
    localparam int AW_DEF       = 5;
    localparam int DW_DEF       = 112;
    localparam int READ_LAT_MIN = 1;
    localparam int READ_LAT_MAX = 4;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SCAN  = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } scan_state_e;

endpackage

// File: rtl/sram_scan_tag_pipe.sv
// Valid bit plus address tag delayed by READ_LAT cycles, so each returning
// SRAM word can be matched to the address that produced it.
module sram_scan_tag_pipe #(
    parameter int READ_LAT = 1,
    parameter int AW       = 5
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          in_valid,
    input  logic [AW-1:0] in_addr,
    output logic          out_valid,
    output logic [AW-1:0] out_addr
);

    logic [READ_LAT-1:0] valid_q;
    logic [READ_LAT-1:0] valid_d;
    logic [AW-1:0]       addr_q [READ_LAT];
    logic [AW-1:0]       addr_d [READ_LAT];

    always_comb begin
        valid_d[0] = in_valid;
        addr_d[0]  = in_addr;
        for (int i = 1; i < READ_LAT; i++) begin
            valid_d[i] = valid_q[i-1];
            addr_d[i]  = addr_q[i-1];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= '0;
            for (int i = 0; i < READ_LAT; i++) begin
                addr_q[i] <= '0;
            end
        end else begin
            valid_q <= valid_d;
            for (int i = 0; i < READ_LAT; i++) begin
                addr_q[i] <= addr_d[i];
            end
        end
    end

    assign out_valid = valid_q[READ_LAT-1];
    assign out_addr  = addr_q[READ_LAT-1];

endmodule

// File: rtl/sram_scan_checker.sv
// Walks every SRAM address once, checks each returned word for zero/X and
// reports pass, good-entry count, first bad address and an XOR checksum.
module sram_scan_checker
    import sram_scan_pkg::*;
#(
    parameter int DEPTH    = DEPTH_DEF,
    parameter int AW       = AW_DEF,
    parameter int DW       = DW_DEF,
    parameter int READ_LAT = 1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    output logic [AW-1:0] read_addr,
    input  logic [DW-1:0] read_data,
    input  logic          is_zero,
    input  logic          has_x,
    output logic          busy,
    output logic          done,
    output logic          pass,
    output logic [AW:0]   zero_count,
    output logic          first_bad_valid,
    output logic [AW-1:0] first_bad_addr,
    output logic [DW-1:0] checksum
);

    localparam logic [AW-1:0] LAST_ADDR  = AW'(DEPTH - 1);
    localparam logic [AW:0]   FULL_COUNT = (AW+1)'(DEPTH);

    scan_state_e   state_q, state_d;
    logic [AW-1:0] addr_q, addr_d;
    logic          pass_q, pass_d;
    logic [AW:0]   zero_count_q, zero_count_d;
    logic          first_bad_valid_q, first_bad_valid_d;
    logic [AW-1:0] first_bad_addr_q, first_bad_addr_d;
    logic [DW-1:0] checksum_q, checksum_d;

    logic          tag_valid;
    logic [AW-1:0] tag_addr;
    logic          entry_bad;

    sram_scan_tag_pipe #(
        .READ_LAT (READ_LAT),
        .AW       (AW)
    ) u_tag_pipe (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (state_q == ST_SCAN),
        .in_addr   (addr_q),
        .out_valid (tag_valid),
        .out_addr  (tag_addr)
    );

    assign entry_bad = !is_zero || has_x;

    always_comb begin
        state_d           = state_q;
        addr_d            = addr_q;
        pass_d            = pass_q;
        zero_count_d      = zero_count_q;
        first_bad_valid_d = first_bad_valid_q;
        first_bad_addr_d  = first_bad_addr_q;
        checksum_d        = checksum_q;

        // Returning data is only ever tagged valid in SCAN or DRAIN.
        if (tag_valid) begin
            checksum_d = checksum_q ^ read_data;
            if (entry_bad) begin
                if (!first_bad_valid_q) begin
                    first_bad_valid_d = 1'b1;
                    first_bad_addr_d  = tag_addr;
                end
            end else if (zero_count_q != FULL_COUNT) begin
                zero_count_d = zero_count_q + (AW+1)'(1);
            end
        end

        case (state_q)
            ST_IDLE, ST_DONE: begin
                addr_d = '0;
                if (start) begin
                    state_d           = ST_SCAN;
                    pass_d            = 1'b0;
                    zero_count_d      = '0;
                    first_bad_valid_d = 1'b0;
                    first_bad_addr_d  = '0;
                    checksum_d        = '0;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_SCAN: begin
                if (addr_q == LAST_ADDR) begin
                    state_d = ST_DRAIN;
                    addr_d  = '0;
                end else begin
                    addr_d = addr_q + AW'(1);
                end
            end
            ST_DRAIN: begin
                // pass must include the final entry, so use the updated values.
                if (tag_valid && (tag_addr == LAST_ADDR)) begin
                    state_d = ST_DONE;
                    pass_d  = (zero_count_d == FULL_COUNT) && !first_bad_valid_d;
                end
            end
            default: begin
                state_d = ST_IDLE;
                addr_d  = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q           <= ST_IDLE;
            addr_q            <= '0;
            pass_q            <= 1'b0;
            zero_count_q      <= '0;
            first_bad_valid_q <= 1'b0;
            first_bad_addr_q  <= '0;
            checksum_q        <= '0;
        end else begin
            state_q           <= state_d;
            addr_q            <= addr_d;
            pass_q            <= pass_d;
            zero_count_q      <= zero_count_d;
            first_bad_valid_q <= first_bad_valid_d;
            first_bad_addr_q  <= first_bad_addr_d;
            checksum_q        <= checksum_d;
        end
    end

    assign read_addr       = (state_q == ST_SCAN) ? addr_q : '0;
    assign busy            = (state_q == ST_SCAN) || (state_q == ST_DRAIN);
    assign done            = (state_q == ST_DONE);
    assign pass            = pass_q;
    assign zero_count      = zero_count_q;
    assign first_bad_valid = first_bad_valid_q;
    assign first_bad_addr  = first_bad_addr_q;
    assign checksum        = checksum_q;

endmodule
